// File: rtl/data_mem_responder.sv
// Data RAM responder for the RV32I load/store port: one request at a time with WAIT_STATES
// wait states. Define DMEM_ALIGN_CHECK_EN to flag misaligned H/W accesses as errors.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busReq,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    input  logic [2:0]  busSize,
    output logic [31:0] busRData,
    output logic        busReady,
    output logic        busErr
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_we;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_size;
    logic [31:0] r_mem [2**ADDR_WIDTH];

    logic                  w_we, w_err, w_commit;
    logic [31:0]           w_addr, w_word, w_load, w_wlanes;
    logic [2:0]            w_size;
    logic [3:0]            w_be;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_unused;

    // In IDLE the live bus is the current transaction, so a zero-wait response can be formed
    // from the same edge that accepts the request.
    assign w_we     = (r_state == StIdle) ? busWe   : r_we;
    assign w_addr   = (r_state == StIdle) ? busAddr : r_addr;
    assign w_size   = (r_state == StIdle) ? busSize : r_size;
    assign w_idx    = w_addr[ADDR_WIDTH+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_unused = ^w_addr[31:ADDR_WIDTH+2];

    always_comb begin
        w_err = (w_size == 3'b011) || (w_size == 3'b110) || (w_size == 3'b111) ||
                (w_we && w_size[2]);
`ifdef DMEM_ALIGN_CHECK_EN
        if (w_size[1:0] == 2'b01 && w_addr[0]) w_err = 1'b1;
        if (w_size[1:0] == 2'b10 && w_addr[1:0] != 2'b00) w_err = 1'b1;
`endif
    end

    always_comb begin
        w_byte = w_word[7:0];
        case (w_addr[1:0])
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load = '0;
        case (w_size)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'b0, w_byte};
            3'b101:  w_load = {16'b0, w_half};
            default: w_load = '0;
        endcase
        if (w_err || w_we) w_load = '0;
    end

    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = r_wdata;
        case (r_size[1:0])
            2'b00: begin
                w_be     = 4'b0001 << r_addr[1:0];
                w_wlanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (busReq) begin
                    w_cnt_next   = 4'(WAIT_STATES);
                    w_state_next = (WAIT_STATES > 0) ? StWait : StResp;
                end
            end
            StWait: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) w_state_next = StResp;
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == StIdle && busReq) begin
                r_we    <= busWe;
                r_addr  <= busAddr;
                r_wdata <= busWData;
                r_size  <= busSize;
            end
            if (w_state_next == StResp && r_state != StResp) r_rdata <= w_load;
        end
    end

    // Stores land on the edge that ends RESP; a reset on that edge drops them.
    assign w_commit = (r_state == StResp) && r_we && !w_err && !reset;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    assign busRData = r_rdata;
    assign busReady = (r_state == StResp) && !reset;
    assign busErr   = (r_state == StResp) && !reset && w_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: two instances (1 and 0 wait states) checked every
// cycle against a byte-array memory model.
module tb_data_mem_responder;

    localparam int AW = 8;
    localparam int NB = 4 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst [2];
    logic        req [2];
    logic        we  [2];
    logic        rdy [2];
    logic        er  [2];
    logic [31:0] addr[2];
    logic [31:0] wd  [2];
    logic [31:0] rd  [2];
    logic [2:0]  sz  [2];

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) u_dut_ws1 (
        .clk(clk), .reset(rst[0]), .busReq(req[0]), .busWe(we[0]), .busAddr(addr[0]),
        .busWData(wd[0]), .busSize(sz[0]), .busRData(rd[0]), .busReady(rdy[0]), .busErr(er[0])
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(rst[1]), .busReq(req[1]), .busWe(we[1]), .busAddr(addr[1]),
        .busWData(wd[1]), .busSize(sz[1]), .busRData(rd[1]), .busReady(rdy[1]), .busErr(er[1])
    );

    int          checks = 0;
    int          errors = 0;
    bit          checking = 1'b0;
    logic        exp_valid[2];
    int          exp_due  [2];
    logic        exp_err  [2];
    logic [31:0] exp_rd   [2];
    logic [31:0] last_rd  [2];
    logic [31:0] cap_rd   [2];
    logic        cap_err  [2];
    int          free_at  [2];
    logic [7:0]  mb [2][NB];

    function automatic int ws(input int u);
        return (u == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Byte-level memory model: what a little-endian RV32I data RAM must return.
    function automatic void model(input int u, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [2:0] s,
                                  output logic e, output logic [31:0] r);
        int n, ba;
        logic [31:0] v;
        n  = (s[1:0] == 2'b00) ? 1 : (s[1:0] == 2'b01) ? 2 : 4;
        ba = int'(a % NB);
        e  = (s == 3'b011) || (s == 3'b110) || (s == 3'b111) || (w && s[2]);
`ifdef DMEM_ALIGN_CHECK_EN
        if (ba % n != 0) e = 1'b1;
`else
        ba = ba - (ba % n);
`endif
        r = 32'h0;
        if (e) return;
        if (w) begin
            for (int i = 0; i < n; i++) mb[u][ba+i] = d[8*i +: 8];
            return;
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[u][ba+i];
        if (!s[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!s[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        r = v;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            for (int u = 0; u < 2; u++) begin
                if (exp_valid[u] && cyc == exp_due[u]) begin
                    chk($sformatf("u%0d ready", u), {31'b0, rdy[u]}, 32'd1);
                    chk($sformatf("u%0d err", u), {31'b0, er[u]}, {31'b0, exp_err[u]});
                    chk($sformatf("u%0d rdata", u), rd[u], exp_rd[u]);
                    cap_rd[u]    = rd[u];
                    cap_err[u]   = er[u];
                    last_rd[u]   = exp_rd[u];
                    exp_valid[u] = 1'b0;
                end else begin
                    chk($sformatf("u%0d idle ready", u), {31'b0, rdy[u]}, 32'd0);
                    chk($sformatf("u%0d hold rdata", u), rd[u], last_rd[u]);
                end
            end
        end
    end

    // Called just after a falling edge. mode 1 scrambles the bus after acceptance,
    // mode 2 drops busReq and re-raises it with a store during the wait.
    task automatic xact(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] s, input int mode);
        int k, due;
        logic e;
        logic [31:0] r;
        k   = (cyc + 1 > free_at[u]) ? cyc + 1 : free_at[u];
        due = k + ws(u);
        model(u, w, a, d, s, e, r);
        exp_err[u] = e; exp_rd[u] = r; exp_due[u] = due; exp_valid[u] = 1'b1;
        req[u] = 1'b1; we[u] = w; addr[u] = a; wd[u] = d; sz[u] = s;
        do begin @(posedge clk); #1; end while (cyc < k);
        if (mode == 1) begin
            we[u] = 1'($urandom); addr[u] = $urandom; wd[u] = $urandom; sz[u] = 3'($urandom);
        end else if (mode == 2) begin
            req[u] = 1'b0;
            #2;
            req[u] = 1'b1; we[u] = 1'b1; addr[u] = 32'h10; wd[u] = 32'h0; sz[u] = 3'b010;
        end
        @(negedge clk);
        while (cyc < due) @(negedge clk);
        #1;
        req[u] = 1'b0;
        free_at[u] = due + 2;
    endtask

    task automatic reset_in_wait(input logic [31:0] a, input logic [31:0] d);
        int k;
        k = (cyc + 1 > free_at[0]) ? cyc + 1 : free_at[0];
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = a; wd[0] = d; sz[0] = 3'b010;
        do begin @(posedge clk); #1; end while (cyc < k);
        rst[0] = 1'b1; req[0] = 1'b0;
        @(posedge clk); #1;
        last_rd[0] = 32'h0; rst[0] = 1'b0; free_at[0] = 0;
        @(negedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req[u] = 1'b0; we[u] = 1'b0; addr[u] = '0; wd[u] = '0; sz[u] = '0;
            exp_valid[u] = 1'b0; exp_due[u] = 0; exp_err[u] = 1'b0; exp_rd[u] = '0;
            last_rd[u] = '0; cap_rd[u] = '0; cap_err[u] = 1'b0; free_at[u] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0; checking = 1'b1;

        for (int u = 0; u < 2; u++)
            for (int i = 0; i < (1 << AW); i++) xact(u, 1'b1, 32'(i * 4), $urandom, 3'b010, 0);

        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
        chk("sw err", {31'b0, cap_err[0]}, 32'd0);
        xact(0, 1'b0, 32'h10, 32'h0, 3'b010, 0);
        chk("lw 0x10", cap_rd[0], 32'hDEADBEEF);

        xact(0, 1'b1, 32'h20, 32'h11, 3'b000, 0);
        xact(0, 1'b1, 32'h21, 32'h22, 3'b000, 1);
        xact(0, 1'b1, 32'h22, 32'h33, 3'b000, 0);
        xact(0, 1'b1, 32'h23, 32'h44, 3'b000, 1);
        xact(0, 1'b0, 32'h20, 32'h0, 3'b010, 0);
        chk("lw bytes", cap_rd[0], 32'h44332211);
        xact(0, 1'b1, 32'h23, 32'h80, 3'b000, 0);
        xact(0, 1'b0, 32'h23, 32'h0, 3'b000, 0);
        chk("lb sext", cap_rd[0], 32'hFFFFFF80);
        xact(0, 1'b0, 32'h23, 32'h0, 3'b100, 0);
        chk("lbu", cap_rd[0], 32'h00000080);

        xact(0, 1'b1, 32'h30, 32'h01234567, 3'b010, 0);
        xact(0, 1'b1, 32'h32, 32'h8001, 3'b001, 0);
        xact(0, 1'b0, 32'h32, 32'h0, 3'b001, 0);
        chk("lh sext", cap_rd[0], 32'hFFFF8001);
        xact(0, 1'b0, 32'h32, 32'h0, 3'b101, 0);
        chk("lhu", cap_rd[0], 32'h00008001);
        xact(0, 1'b0, 32'h30, 32'h0, 3'b010, 0);
        chk("lw after sh", cap_rd[0], 32'h80014567);

        xact(0, 1'b1, 32'h40, 32'hAAAA5555, 3'b010, 0);
        xact(0, 1'b1, 32'h41, 32'h12345678, 3'b010, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("misaligned sw err", {31'b0, cap_err[0]}, 32'd1);
        xact(0, 1'b0, 32'h40, 32'h0, 3'b010, 0);
        chk("lw after misaligned", cap_rd[0], 32'hAAAA5555);
`else
        chk("misaligned sw err", {31'b0, cap_err[0]}, 32'd0);
        xact(0, 1'b0, 32'h40, 32'h0, 3'b010, 0);
        chk("lw after misaligned", cap_rd[0], 32'h12345678);
`endif

        xact(0, 1'b0, 32'h10, 32'h0, 3'b011, 0);
        chk("bad size err", {31'b0, cap_err[0]}, 32'd1);
        chk("bad size rdata", cap_rd[0], 32'h0);
        xact(0, 1'b1, 32'h10, 32'h55, 3'b100, 0);
        chk("store bu err", {31'b0, cap_err[0]}, 32'd1);
        xact(0, 1'b0, 32'h10, 32'h0, 3'b010, 2);
        chk("lw with pulse", cap_rd[0], 32'hDEADBEEF);
        xact(0, 1'b0, 32'h10, 32'h0, 3'b010, 0);
        chk("pulse ignored", cap_rd[0], 32'hDEADBEEF);

        xact(0, 1'b1, 32'h50, 32'h50505050, 3'b010, 0);
        xact(0, 1'b0, 32'h50, 32'h0, 3'b010, 0);
        reset_in_wait(32'h50, 32'hCAFEF00D);
        xact(0, 1'b0, 32'h50, 32'h0, 3'b010, 0);
        chk("lw after reset", cap_rd[0], 32'h50505050);

        xact(1, 1'b1, 32'h60, 32'h0BADC0DE, 3'b010, 0);
        xact(1, 1'b0, 32'h60, 32'h0, 3'b010, 0);
        chk("ws0 lw", cap_rd[1], 32'h0BADC0DE);
        xact(1, 1'b0, 32'h1000_0062, 32'h0, 3'b001, 1);
        chk("ws0 aliased lh", cap_rd[1], 32'h00000BAD);

        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 400; n++) begin
                xact(u, 1'($urandom), $urandom, $urandom, 3'($urandom),
                     int'($urandom_range(0, 1)));
            end
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Bus responder (data RAM) for the RV32I core's load/store port: accepts one request at a time, performs byte/half/word access, returns sign- or zero-extended read data.
- Adds a request/ready handshake with configurable wait states, so the core can be moved toward multi-cycle or stallable memory.
- Sits between the core's bus-initiator signals (address, write data, read data) and on-chip block RAM.

Parameters:
- ADDR_WIDTH, 8, word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles between request acceptance and response (0..15).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- busReq  in  1  request valid; sampled only in IDLE
- busWe  in  1  1 = store, 0 = load
- busAddr  in  32  byte address; bits above ADDR_WIDTH+1 ignored (aliasing)
- busWData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- busSize  in  3  func3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- busRData  out  32  load result, extended; valid when busReady=1
- busReady  out  1  one-cycle response strobe
- busErr  out  1  error flag, valid when busReady=1

Behaviour:
- Clocking: single clock. Reset is synchronous, active-high, named reset; clock named clk.
- Reset: FSM=IDLE, wait counter=0, busReady=0, busErr=0, busRData=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE with busReq=1: latch busWe, busAddr, busWData, busSize; load counter with WAIT_STATES; compute error.
  - Next state: WAIT if WAIT_STATES>0, else RESP.
- WAIT: decrement counter each cycle; go to RESP when the counter reaches 1.
- RESP: busReady=1 for exactly one cycle, busErr valid. Next state is always IDLE.
- Latency: request sampled at edge N; busReady high during cycle N+WAIT_STATES+1.
- Throughput: one transaction per WAIT_STATES+2 cycles. busReq outside IDLE is ignored; the initiator holds the request until busReady.
- Store commit: RAM written at the clock edge that ends RESP, only if busErr=0.
  - Little-endian byte lanes selected by addr[1:0].
  - SB writes lane addr[1:0]. SH writes lanes {addr[1],0} and {addr[1],1}. SW writes all four lanes.
- Load: busRData registered, updated on entry to RESP.
  - Lane extracted by addr[1:0].
  - B/H: sign-extended from bit 7/15. BU/HU: zero-extended. W: unmodified.
- busRData holds its last value outside RESP. Loads on error return busRData=0.
- Stores: busRData=0 in RESP.
- Error conditions (busErr=1 in RESP):
  - busSize in {011, 110, 111};
  - store with size BU/HU;
  - misalignment, as defined by the optional feature.
- Simultaneous events: reset has priority over everything.
- Reset during WAIT or RESP: return to IDLE; pending store discarded; busReady not asserted.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: H access with addr[0]=1, or W access with addr[1:0]!=0, gives busErr=1, no write, busRData=0.
- Undefined: misaligned addresses are silently aligned (H clears addr[0]; W clears addr[1:0]). The access completes normally with busErr=0; busErr is driven only by the size errors.

Test Plan:
- WAIT_STATES=1: SW 0xDEADBEEF @0x10 at edge N -> busReady high cycle N+2 only, busErr=0; LW @0x10 -> busRData=0xDEADBEEF.
- SB 0x11,0x22,0x33,0x44 to @0x20..0x23, then LW @0x20 -> 0x44332211; LB @0x23 after SB 0x80 -> 0xFFFFFF80; LBU -> 0x00000080.
- SH 0x8001 @0x32; LH @0x32 -> 0xFFFF8001, LHU -> 0x00008001; LW @0x30 upper half = 0x8001, lower half unchanged.
- Macro defined: SW 0x12345678 @0x41 -> busReady with busErr=1, LW @0x40 unchanged. Macro undefined: same store writes @0x40, busErr=0.
- busSize=011 load -> busErr=1, busRData=0. busReq pulsed during WAIT -> ignored, exactly one busReady.
- SW 0xCAFEF00D @0x50 then reset asserted in WAIT -> no busReady, LW @0x50 returns the prior value. WAIT_STATES=0 -> busReady at N+1.
